// File: rtl/n_term_sm_pkg.sv
// n_term_sm_pkg: shared modes, widths and LFSR constants for the N-term loopback matrix
package n_term_sm_pkg;
  typedef enum logic [1:0] {PASS = 2'b00, REG = 2'b01, TIE = 2'b10, PAT = 2'b11} mode_e;
  localparam int CFG_W = 8;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;
  function automatic logic mode_bit(mode_e m, logic pass_b, logic reg_b, logic pat_b);
    return m == PASS ? pass_b : m == REG ? reg_b : m == TIE ? 1'b0 : pat_b;
  endfunction
endpackage

// File: rtl/term_lfsr16.sv
// term_lfsr16: 16-bit Fibonacci LFSR that steps only when advance is high
module term_lfsr16
  import n_term_sm_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              advance,
  output logic [LFSR_W-1:0] q
);
  always_ff @(posedge clk)
    if (!resetn) q <= SEED;
    else if (advance) q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/n_term_loopback_switch_matrix.sv
// n_term_loopback_switch_matrix: loops north wires back south with per-group PASS/REG/TIE/PAT modes
module n_term_loopback_switch_matrix
  import n_term_sm_pkg::*;
#(
  parameter int NUM_SINGLE = 4,
  parameter int NUM_DOUBLE = 8,
  parameter int NUM_QUAD   = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic                  UserCLK,
  input  logic                  resetn,
  input  logic [NUM_SINGLE-1:0] N1END,
  input  logic [NUM_DOUBLE-1:0] N2MID,
  input  logic [NUM_DOUBLE-1:0] N2END,
  input  logic [NUM_QUAD-1:0]   N4END,
  output logic [NUM_SINGLE-1:0] S1BEG,
  output logic [NUM_DOUBLE-1:0] S2BEG,
  output logic [NUM_DOUBLE-1:0] S2BEGb,
  output logic [NUM_QUAD-1:0]   S4BEG,
  input  logic                  cfg_en,
  input  logic                  cfg_din,
  input  logic                  cfg_commit,
  output logic                  cfg_dout
);
  logic [CFG_W-1:0] shadow, active;
  logic [NUM_SINGLE-1:0] rev1, pipe1;
  logic [NUM_DOUBLE-1:0] rev2, pipe2, rev2b, pipe2b;
  logic [NUM_QUAD-1:0] rev4, pipe4;
  logic [LFSR_W-1:0] lfsr;
  logic adv;
  mode_e m1, m2, m2b, m4;
  assign m1 = mode_e'(active[1:0]);
  assign m2 = mode_e'(active[3:2]);
  assign m2b = mode_e'(active[5:4]);
  assign m4 = mode_e'(active[7:6]);
  assign adv = m1 == PAT || m2 == PAT || m2b == PAT || m4 == PAT;
  assign cfg_dout = shadow[CFG_W-1];
  // commit reads the pre-shift shadow because both updates are non-blocking
  always_ff @(posedge UserCLK)
    if (!resetn) begin
      shadow <= '0;
      active <= '0;
      pipe1 <= '0;
      pipe2 <= '0;
      pipe2b <= '0;
      pipe4 <= '0;
    end else begin
      if (cfg_en) shadow <= {shadow[CFG_W-2:0], cfg_din};
      if (cfg_commit) active <= shadow;
      pipe1 <= rev1;
      pipe2 <= rev2;
      pipe2b <= rev2b;
      pipe4 <= rev4;
    end
  term_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(UserCLK), .resetn(resetn), .advance(adv), .q(lfsr)
  );
  for (genvar i = 0; i < NUM_SINGLE; i++) begin : g_s1
    assign rev1[i] = N1END[NUM_SINGLE-1-i];
    assign S1BEG[i] = mode_bit(m1, rev1[i], pipe1[i], lfsr[i % LFSR_W]);
  end
  for (genvar i = 0; i < NUM_DOUBLE; i++) begin : g_s2
    assign rev2[i] = N2MID[NUM_DOUBLE-1-i];
    assign S2BEG[i] = mode_bit(m2, rev2[i], pipe2[i], lfsr[i % LFSR_W]);
  end
  for (genvar i = 0; i < NUM_DOUBLE; i++) begin : g_s2b
    assign rev2b[i] = N2END[NUM_DOUBLE-1-i];
    assign S2BEGb[i] = mode_bit(m2b, rev2b[i], pipe2b[i], lfsr[i % LFSR_W]);
  end
  for (genvar i = 0; i < NUM_QUAD; i++) begin : g_s4
    assign rev4[i] = N4END[NUM_QUAD-1-i];
    assign S4BEG[i] = mode_bit(m4, rev4[i], pipe4[i], lfsr[i % LFSR_W]);
  end
endmodule

// File: tb/tb_n_term_loopback_switch_matrix.sv
// tb_n_term_loopback_switch_matrix: directed and random checks against a behavioural model
module tb_n_term_loopback_switch_matrix;
  logic UserCLK = 0, resetn = 0, cfg_en = 0, cfg_din = 0, cfg_commit = 0, cfg_dout;
  logic [3:0] N1END = 0, S1BEG;
  logic [7:0] N2MID = 0, N2END = 0, S2BEG, S2BEGb;
  logic [15:0] N4END = 0, S4BEG;
  int checks = 0, failures = 0;
  logic [7:0] m_shadow, m_active;
  logic [15:0] m_lfsr, p1, p2, p2b, p4;

  n_term_loopback_switch_matrix dut (
    .UserCLK(UserCLK), .resetn(resetn), .N1END(N1END), .N2MID(N2MID), .N2END(N2END),
    .N4END(N4END), .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG),
    .cfg_en(cfg_en), .cfg_din(cfg_din), .cfg_commit(cfg_commit), .cfg_dout(cfg_dout)
  );

  always #5 UserCLK = ~UserCLK;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rev(logic [15:0] v, int w);
    logic [15:0] r = 0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

  function automatic logic [15:0] pat(int w);
    logic [15:0] r = 0;
    for (int i = 0; i < w; i++) r[i] = m_lfsr[i % 16];
    return r;
  endfunction

  function automatic logic [15:0] exp_grp(int g, int w, logic [15:0] cur, logic [15:0] prev);
    int m = int'((m_active >> (2 * g)) & 8'd3);
    if (m == 0) return rev(cur, w);
    if (m == 1) return rev(prev, w);
    if (m == 2) return 16'h0;
    return pat(w);
  endfunction

  task automatic model_edge();
    logic any_pat = 0;
    for (int g = 0; g < 4; g++) if (((m_active >> (2 * g)) & 8'd3) == 8'd3) any_pat = 1;
    if (!resetn) begin
      m_shadow = 0; m_active = 0; m_lfsr = 16'hACE1;
      p1 = 0; p2 = 0; p2b = 0; p4 = 0;
    end else begin
      if (cfg_commit) m_active = m_shadow;
      if (cfg_en) m_shadow = {m_shadow[6:0], cfg_din};
      if (any_pat) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      p1 = 16'(N1END); p2 = 16'(N2MID); p2b = 16'(N2END); p4 = N4END;
    end
  endtask

  task automatic settle();
    @(negedge UserCLK);
    chk("s1", 16'(S1BEG), exp_grp(0, 4, 16'(N1END), p1));
    chk("s2", 16'(S2BEG), exp_grp(1, 8, 16'(N2MID), p2));
    chk("s2b", 16'(S2BEGb), exp_grp(2, 8, 16'(N2END), p2b));
    chk("s4", S4BEG, exp_grp(3, 16, N4END, p4));
    chk("dout", 16'(cfg_dout), 16'(m_shadow[7]));
  endtask

  task automatic edge_step();
    @(posedge UserCLK);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    settle();
    edge_step();
  endtask

  task automatic shift(logic [7:0] b, bit commit_last);
    for (int i = 7; i >= 0; i--) begin
      cfg_en = 1; cfg_din = b[i]; cfg_commit = commit_last && i == 0;
      cycle();
    end
    cfg_en = 0; cfg_din = 0; cfg_commit = 0;
  endtask

  task automatic commit();
    cfg_commit = 1;
    cycle();
    cfg_commit = 0;
  endtask

  initial begin
    @(posedge UserCLK);
    model_edge();
    #1;
    edge_step();
    resetn = 1;
    // 1: PASS after reset
    N4END = 16'h0001; N1END = 4'b0011;
    settle();
    chk("t1_s4", S4BEG, 16'h8000);
    chk("t1_s1", 16'(S1BEG), 16'hC);
    edge_step();
    // 2: group0 REG
    shift(8'b0000_0001, 0);
    commit();
    N1END = 4'h1; N2MID = 8'h01;
    settle();
    chk("t2_s2_pass", 16'(S2BEG), 16'h80);
    edge_step();
    N1END = 4'h2;
    settle();
    chk("t2_s1_a", 16'(S1BEG), 16'h8);
    edge_step();
    N1END = 4'h0;
    settle();
    chk("t2_s1_b", 16'(S1BEG), 16'h4);
    edge_step();
    // 3: group3 PAT
    shift(8'b1100_0000, 0);
    commit();
    settle();
    chk("t3_seed", S4BEG, 16'hACE1);
    edge_step();
    settle();
    chk("t3_next", S4BEG, 16'h59C3);
    edge_step();
    // 4: commit on last shift edge, then TIE on both double groups
    N2MID = 8'h5A; N2END = 8'hC3;
    shift(8'b0010_1000, 1);
    commit();
    settle();
    chk("t4_s2", 16'(S2BEG), 16'h0);
    chk("t4_s2b", 16'(S2BEGb), 16'h0);
    edge_step();
    // 5: PAT running, reset mid-shift
    shift(8'b1100_0000, 1);
    commit();
    repeat (5) cycle();
    cfg_en = 1; cfg_din = 1;
    repeat (3) cycle();
    resetn = 0;
    cycle();
    resetn = 1; cfg_en = 0; cfg_din = 0;
    N4END = 16'h1234;
    settle();
    chk("t5_s4", S4BEG, 16'h2C48);
    chk("t5_dout", 16'(cfg_dout), 16'h0);
    edge_step();
    shift(8'b1100_0000, 0);
    commit();
    settle();
    chk("t5_seed", S4BEG, 16'hACE1);
    edge_step();
    // random phase
    for (int n = 0; n < 400; n++) begin
      N1END = 4'($urandom); N2MID = 8'($urandom); N2END = 8'($urandom); N4END = 16'($urandom);
      cfg_en = 1'($urandom_range(0, 1));
      cfg_din = 1'($urandom_range(0, 1));
      cfg_commit = $urandom_range(0, 7) == 0;
      resetn = $urandom_range(0, 49) != 0;
      cycle();
    end
    resetn = 1; cfg_en = 0; cfg_commit = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
